serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
Parallel-to-serial transmitter. It is the driving end of the single-bit enable-gated capture link (`en`/`d` into a posedge D flip-flop). It accepts a WIDTH-bit word over a valid/ready handshake. It then emits the word one bit per clock on `ser_d`, with `ser_en` high for exactly those bit cycles, so a downstream enable-gated capture register samples each bit on the following edge.

Parameters:
- WIDTH, 8: bits per word; legal values are 2 to 32.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- IDLE_GAP, 1: number of cycles with `ser_en` low forced between words; 0 allows back-to-back words.

Ports:
- clk, input, 1: single clock; all logic is posedge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: `in_data` holds a word to send.
- in_ready, output, 1: block can accept a word this cycle.
- in_data, input, WIDTH: word to serialize.
- ser_en, output, 1: high during each bit cycle.
- ser_d, output, 1: current serial bit; 0 whenever `ser_en` is 0.
- busy, output, 1: high in SHIFT or GAP.
- done, output, 1: one-cycle pulse after the last bit of a word.

Behaviour:
- Interface fixed: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - state = IDLE;
  - `ser_en`, `ser_d`, `busy` and `done` = 0;
  - shift register and counters = 0;
  - `in_ready` = 1 once `rst_n` deasserts.
- `ser_en`, `ser_d`, `busy` and `done` are driven directly from flops. `in_ready` is a decode of state only and never depends on `in_valid`.
- Transfer occurs on a posedge where `in_valid` and `in_ready` are both 1. `in_data` is captured into the shift register on that edge.
- States:
  - IDLE: `in_ready` = 1, `ser_en` = 0. On transfer go to SHIFT.
  - SHIFT: lasts exactly WIDTH cycles with `ser_en` = 1.
    - Bit k (k = 0..WIDTH-1) is sent in the k-th SHIFT cycle: `in_data[WIDTH-1-k]` if MSB_FIRST, else `in_data[k]`.
    - Bit counter width is `$clog2(WIDTH)`; it counts 0..WIDTH-1 and does not wrap within a word.
    - After the last bit, go to GAP if IDLE_GAP > 0, else IDLE.
  - GAP: `ser_en` = 0, `in_ready` = 0. Lasts exactly IDLE_GAP cycles, then go to IDLE.
- Latency: for a transfer at edge N, bit 0 is on `ser_d` with `ser_en` = 1 in the cycle after edge N. The last bit is in cycle N+WIDTH.
- `done` = 1 in cycle N+WIDTH+1 only, the first non-SHIFT cycle or the first bit of the next word.
- Back-to-back (IDLE_GAP = 0):
  - `in_ready` is also 1 during the last SHIFT cycle.
  - A transfer there loads the next word, so its first bit follows the previous last bit with no gap.
  - `ser_en` stays high, and `done` pulses concurrently with the new word's first bit.
- `in_data` changes while SHIFT or GAP are ignored; the captured word is sent unchanged.
- `in_valid` held high in IDLE with no new data resends the word. This is the caller's responsibility.
- `rst_n` asserted mid-word: all outputs drop to reset values immediately (asynchronously). The partial word is discarded and no `done` pulse occurs.
- `busy` = 1 exactly while state is SHIFT or GAP.

Decomposition:
- Shared package `serial_link_pkg` holds:
  - the state encoding constants (IDLE, SHIFT, GAP);
  - the default WIDTH;
  - the MSB_FIRST convention constant, so the matching receiver uses the same bit order.
- One sub-module is natural: `shift_reg_piso`, a parallel-load, direction-selectable shift register with load/shift enables. The FSM and counters stay in `serial_tx`.

Test Plan:
1. Reset then single word: WIDTH = 8, MSB_FIRST = 1, send 0xA5 at edge N.
   - `ser_d` sequence 1,0,1,0,0,1,0,1 with `ser_en` high in cycles N+1..N+8.
   - `done` high in cycle N+9 only.
   - `in_ready` low in N+1..N+9 (IDLE_GAP = 1), high again in N+10.
2. LSB-first: MSB_FIRST = 0, send 0x01.
   - First bit 1, then seven 0s.
   - A downstream enable-gated capture register chain reassembles 0x01.
3. Back-to-back: IDLE_GAP = 0, `in_valid` held with 0xFF then 0x00.
   - 16 consecutive `ser_en` = 1 cycles: eight 1s then eight 0s.
   - `done` pulses together with the first bit of 0x00 and again after the last bit.
4. Data hold: send 0x3C, then change `in_data` to 0xC3 during SHIFT.
   - Output is still 0,0,1,1,1,1,0,0.
   - 0xC3 is sent only if `in_valid` is high in the next IDLE.
5. Mid-word reset: assert `rst_n` = 0 during bit 4 of 0x96.
   - `ser_en`, `ser_d`, `busy` and `done` go to 0 immediately, with no `done` pulse.
   - After release, `in_ready` = 1, and a new word 0x5A is sent correctly from bit 0.
6. Idle stability: `in_valid` = 0 for 20 cycles after reset.
   - `ser_en` = 0, `ser_d` = 0, `busy` = 0 and `in_ready` = 1 throughout.

Source files
------------

// File: rtl/serial_link_pkg.sv
// serial_link_pkg: definitions shared by the transmitter and the matching
// enable-gated receiver, so both ends agree on word size and bit order.
//   tx_state_e      : transmitter FSM state encoding (IDLE, SHIFT, GAP)
//   SER_WIDTH       : default bits per word
//   SER_MSB_FIRST   : default bit order (1 = bit WIDTH-1 goes out first)
//   SER_IDLE_GAP    : default number of forced idle cycles between words
//   cnt_bits()      : counter width able to hold 0..n-1, never below 1 bit
package serial_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_e;

    localparam int SER_WIDTH     = 8;
    localparam bit SER_MSB_FIRST = 1'b1;
    localparam int SER_IDLE_GAP  = 1;

    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_tx_if.sv
// serial_tx_if: word-input handshake plus serial link outputs of serial_tx.
//   in_valid/in_ready/in_data : word handshake into the transmitter
//   ser_en/ser_d              : enable-gated serial bit stream
//   busy/done                 : word-level status
//   dbg_state                 : transmitter FSM state, observation only
//
// Handshake: a word transfers on every rising clk edge where in_valid and
// in_ready are both 1. in_ready is a function of transmitter state only and
// never looks at in_valid; in_data is sampled only on a transfer edge.
interface serial_tx_if
    import serial_link_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             ser_en;
    logic             ser_d;
    logic             busy;
    logic             done;
    tx_state_e        dbg_state;

    // Word source side
    modport master (
        output in_valid, in_data,
        input  in_ready, ser_en, ser_d, busy, done, dbg_state
    );

    // Transmitter side
    modport slave (
        input  in_valid, in_data,
        output in_ready, ser_en, ser_d, busy, done, dbg_state
    );

endinterface

// File: rtl/shift_reg_piso.sv
// shift_reg_piso: parallel-load, direction-selectable shift register.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : load i_data (has priority over i_shift)
//   i_shift        : move one bit toward the output end, filling with 0
//   i_data         : parallel word
//   o_bit          : output-end bit (MSB when MSB_FIRST, else LSB)
// Zero fill means the output bit falls to 0 once a word has drained, which
// keeps the serial data line low between words without extra gating.
module shift_reg_piso
    import serial_link_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH,
    parameter bit MSB_FIRST = SER_MSB_FIRST
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_bit
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end else if (i_shift) begin
            r_data <= MSB_FIRST ? {r_data[WIDTH-2:0], 1'b0}
                                : {1'b0, r_data[WIDTH-1:1]};
        end
    end

    assign o_bit = MSB_FIRST ? r_data[WIDTH-1] : r_data[0];

endmodule

// File: rtl/serial_tx.sv
// serial_tx: parallel-to-serial transmitter driving an enable-gated capture
// link. Accepts a WIDTH-bit word over valid/ready, then emits it one bit per
// clock on ser_d with ser_en high for exactly those WIDTH cycles, followed by
// IDLE_GAP forced idle cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : serial_tx_if.slave (handshake, serial outputs, status, state)
// ser_en, ser_d, busy and done all come straight from flops.
module serial_tx
    import serial_link_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH,
    parameter bit MSB_FIRST = SER_MSB_FIRST,
    parameter int IDLE_GAP  = SER_IDLE_GAP
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_tx_if.slave   bus
);

    localparam int CW = $clog2(WIDTH);
    localparam int GW = cnt_bits(IDLE_GAP);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

    tx_state_e         r_state;
    tx_state_e         w_state_nxt;
    logic [CW-1:0]     r_bit_cnt;
    logic [CW-1:0]     w_bit_cnt_nxt;
    logic [GW-1:0]     r_gap_cnt;
    logic [GW-1:0]     w_gap_cnt_nxt;
    logic              r_ser_en;
    logic              r_busy;
    logic              r_done;
    logic              w_last_bit;
    logic              w_in_ready;
    logic              w_xfer;
    logic              w_ser_d;

    assign w_last_bit = (r_state == ST_SHIFT) && (r_bit_cnt == BIT_LAST);

    // With no gap the next word may load during the last bit cycle, so the
    // stream continues without a hole.
    assign w_in_ready = (r_state == ST_IDLE) ||
                        ((IDLE_GAP == 0) && w_last_bit);
    assign w_xfer     = bus.in_valid && w_in_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt   = ST_SHIFT;
                    w_bit_cnt_nxt = '0;
                end
            end
            ST_SHIFT: begin
                if (w_last_bit) begin
                    w_bit_cnt_nxt = '0;
                    if (IDLE_GAP > 0) begin
                        w_state_nxt   = ST_GAP;
                        w_gap_cnt_nxt = '0;
                    end else if (w_xfer) begin
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + CW'(1);
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt   = ST_IDLE;
                    w_gap_cnt_nxt = '0;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + GW'(1);
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_bit_cnt_nxt = '0;
                w_gap_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_ser_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            // Output flops take the decode of the next state so they line up
            // with the state they describe.
            r_ser_en  <= (w_state_nxt == ST_SHIFT);
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_done    <= w_last_bit;
        end
    end

    // The register's output end holds the current bit during SHIFT and 0
    // otherwise, so it doubles as the ser_d flop.
    shift_reg_piso #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_load  (w_xfer),
        .i_shift (r_state == ST_SHIFT),
        .i_data  (bus.in_data),
        .o_bit   (w_ser_d)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.ser_en    = r_ser_en;
    assign bus.ser_d     = w_ser_d;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: three transmitter instances side by side
//   a: MSB first, one idle gap cycle
//   b: LSB first, one idle gap cycle
//   c: MSB first, back-to-back words (no gap)
// Expected per-cycle outputs come from a timeline model: a transfer at edge N
// fills bit cycles N+1..N+WIDTH, done at N+WIDTH+1, then the gap cycles.
module tb_serial_tx;
    import serial_link_pkg::*;

    localparam int W    = 8;
    localparam int NI   = 3;
    localparam int MAXC = 1024;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    serial_tx_if #(.WIDTH(W)) ia ();
    serial_tx_if #(.WIDTH(W)) ib ();
    serial_tx_if #(.WIDTH(W)) ic ();

    serial_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_GAP(1)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(ia));
    serial_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_GAP(1)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(ib));
    serial_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_GAP(0)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(ic));

    // Downstream enable-gated capture chains (receivers)
    logic [W-1:0] cap_a;
    logic [W-1:0] cap_b;
    always @(posedge clk) begin
        if (ia.ser_en) cap_a <= {cap_a[W-2:0], ia.ser_d};
        if (ib.ser_en) cap_b <= {ib.ser_d, cap_b[W-1:1]};
    end

    // Timeline model, indexed by cycle number
    bit e_en   [NI][MAXC];
    bit e_d    [NI][MAXC];
    bit e_done [NI][MAXC];
    bit e_busy [NI][MAXC];
    bit e_rdy  [NI][MAXC];

    logic [W-1:0] exp_q_a[$];
    logic [W-1:0] exp_q_b[$];

    int cyc;
    int n_vec;
    int n_err;
    bit xfer [NI];

    function automatic bit inst_msb(int i);
        return (i != 1);
    endfunction

    function automatic int inst_gap(int i);
        return (i == 2) ? 0 : 1;
    endfunction

    task automatic model_clear(int from);
        for (int i = 0; i < NI; i++) begin
            for (int c = from; c < MAXC; c++) begin
                e_en[i][c]   = 1'b0;
                e_d[i][c]    = 1'b0;
                e_done[i][c] = 1'b0;
                e_busy[i][c] = 1'b0;
                e_rdy[i][c]  = 1'b1;
            end
        end
    endtask

    task automatic model_schedule(int i, int n, logic [W-1:0] w);
        int g;
        int c;
        g = inst_gap(i);
        for (int k = 0; k < W; k++) begin
            c = n + 1 + k;
            if (c < MAXC) begin
                e_en[i][c]   = 1'b1;
                e_d[i][c]    = inst_msb(i) ? 1'((w >> (W - 1 - k)) & 1)
                                           : 1'((w >> k) & 1);
                e_busy[i][c] = 1'b1;
                e_rdy[i][c]  = 1'b0;
            end
        end
        if (n + W < MAXC) e_rdy[i][n + W] = (g == 0);
        if (n + W + 1 < MAXC) e_done[i][n + W + 1] = 1'b1;
        for (int j = 1; j <= g; j++) begin
            c = n + W + j;
            if (c < MAXC) begin
                e_busy[i][c] = 1'b1;
                e_rdy[i][c]  = 1'b0;
            end
        end
    endtask

    function automatic logic [4:0] exp_vec(int i);
        return {e_en[i][cyc], e_d[i][cyc], e_done[i][cyc], e_busy[i][cyc], e_rdy[i][cyc]};
    endfunction

    task automatic check_vec(string tag, logic [4:0] obs, logic [4:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed{en,d,done,busy,rdy}=%b required=%b",
                   tag, cyc, obs, expv);
        end
    endtask

    task automatic check_rst(string tag);
        n_vec++;
        assert ({ia.ser_en, ia.ser_d, ia.done, ia.busy,
                 ib.ser_en, ib.ser_d, ib.done, ib.busy,
                 ic.ser_en, ic.ser_d, ic.done, ic.busy} === 12'h000) else begin
            n_err++;
            $error("FAIL %s observed a=%b%b%b%b b=%b%b%b%b c=%b%b%b%b required all 0",
                   tag, ia.ser_en, ia.ser_d, ia.done, ia.busy,
                   ib.ser_en, ib.ser_d, ib.done, ib.busy,
                   ic.ser_en, ic.ser_d, ic.done, ic.busy);
        end
    endtask

    task automatic check_cap(string tag, logic [W-1:0] obs, int i);
        logic [W-1:0] want;
        n_vec++;
        if ((i == 0 && exp_q_a.size() == 0) || (i == 1 && exp_q_b.size() == 0)) begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%h required=<no word pending>", tag, cyc, obs);
        end else begin
            want = (i == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
            assert (obs === want) else begin
                n_err++;
                $error("FAIL %s cyc=%0d observed=%h required=%h", tag, cyc, obs, want);
            end
        end
    endtask

    task automatic set_in(int i, bit v, logic [W-1:0] d);
        case (i)
            0: begin ia.in_valid = v; ia.in_data = d; end
            1: begin ib.in_valid = v; ib.in_data = d; end
            default: begin ic.in_valid = v; ic.in_data = d; end
        endcase
    endtask

    // One clock: model transfers on the edge, then check the new cycle.
    task automatic tick();
        @(posedge clk);
        xfer[0] = (ia.in_valid === 1'b1) && e_rdy[0][cyc];
        xfer[1] = (ib.in_valid === 1'b1) && e_rdy[1][cyc];
        xfer[2] = (ic.in_valid === 1'b1) && e_rdy[2][cyc];
        if (xfer[0]) begin model_schedule(0, cyc, ia.in_data); exp_q_a.push_back(ia.in_data); end
        if (xfer[1]) begin model_schedule(1, cyc, ib.in_data); exp_q_b.push_back(ib.in_data); end
        if (xfer[2]) model_schedule(2, cyc, ic.in_data);
        cyc++;
        if (cyc >= MAXC - W - 4) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - W - 4);
            $fatal(1, "cycle budget exhausted");
        end
        @(negedge clk);
        check_vec("out_a", {ia.ser_en, ia.ser_d, ia.done, ia.busy, ia.in_ready}, exp_vec(0));
        check_vec("out_b", {ib.ser_en, ib.ser_d, ib.done, ib.busy, ib.in_ready}, exp_vec(1));
        check_vec("out_c", {ic.ser_en, ic.ser_d, ic.done, ic.busy, ic.in_ready}, exp_vec(2));
        if (e_done[0][cyc]) check_cap("capture_a", cap_a, 0);
        if (e_done[1][cyc]) check_cap("capture_b", cap_b, 1);
    endtask

    task automatic wait_xfer(int i, string tag);
        int t;
        t = 0;
        do begin
            tick();
            t++;
        end while (!xfer[i] && t < 40);
        n_vec++;
        assert (xfer[i] === 1'b1) else begin
            n_err++;
            $error("FAIL %s observed=no transfer in %0d cycles required=transfer", tag, t);
        end
    endtask

    task automatic send(int i, logic [W-1:0] w, string tag);
        set_in(i, 1'b1, w);
        wait_xfer(i, tag);
        set_in(i, 1'b0, w);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) set_in(i, 1'b0, '0);
        model_clear(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_rst("reset_outputs");
        rst_n = 1'b1;

        // Idle stability
        repeat (20) tick();

        // Single word, MSB first, gap of one
        send(0, 8'hA5, "xfer_a5");
        repeat (10) tick();

        // LSB first, reassembled by the capture chain
        send(1, 8'h01, "xfer_01");
        repeat (10) tick();

        // Back-to-back words with valid held
        set_in(2, 1'b1, 8'hFF);
        wait_xfer(2, "xfer_ff");
        set_in(2, 1'b1, 8'h00);
        wait_xfer(2, "xfer_00");
        set_in(2, 1'b0, 8'h00);
        repeat (12) tick();

        // Data hold: in_data changes during SHIFT are ignored
        send(0, 8'h3C, "xfer_3c");
        set_in(0, 1'b0, 8'hC3);
        repeat (3) tick();
        set_in(0, 1'b1, 8'hC3);
        wait_xfer(0, "xfer_c3");
        set_in(0, 1'b0, 8'hC3);
        repeat (12) tick();

        // Mid-word reset during bit 4
        send(0, 8'h96, "xfer_96");
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1 check_rst("reset_async");
        exp_q_a.delete();
        exp_q_b.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_rst("reset_held");
        rst_n = 1'b1;
        model_clear(cyc);
        send(0, 8'h5A, "xfer_5a");
        repeat (10) tick();

        // Random traffic on all instances
        repeat (250) begin
            for (int i = 0; i < NI; i++)
                set_in(i, ($urandom_range(0, 3) == 0), W'($urandom));
            tick();
        end
        for (int i = 0; i < NI; i++) set_in(i, 1'b0, '0);
        repeat (12) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
